sklansky_sub_pipe: RTL and testbench

//  Pipelined WIDTH-bit subtractor: diff = a - b - bin, plus borrow-out.

---
 rtl/sklansky_sub_pipe.sv | 130 +++++++++++++
 tb/tb_sklansky_sub_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sklansky_sub_pipe.sv
// Three-stage pipelined subtractor (a - b - bin) built on a Sklansky prefix carry network.
// Optional ADDSUB_MODE_EN adds an op input selecting add (0) or subtract (1).
module sklansky_sub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef ADDSUB_MODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int LVL = $clog2(WIDTH);

    // Group generate for every bit with the carry-in folded into bit 0.
    // In-place update is safe: at level l the source bit j always has bit l clear,
    // so it is never rewritten during that level.
    function automatic logic [WIDTH-1:0] sklansky_carry(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input logic             cin
    );
        logic [WIDTH-1:0] gv;
        logic [WIDTH-1:0] pv;
        gv    = g_in;
        pv    = p_in;
        gv[0] = g_in[0] | (p_in[0] & cin);
        for (int l = 0; l < LVL; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> l) & 1) == 1) begin
                    gv[i] = gv[i] | (pv[i] & gv[((i >> (l + 1)) << (l + 1)) + (1 << l) - 1]);
                    pv[i] = pv[i] & pv[((i >> (l + 1)) << (l + 1)) + (1 << l) - 1];
                end
            end
        end
        return gv;
    endfunction

    logic             vld_p1, vld_p2, vld_p3;
    logic             ld_p1, ld_p2, ld_p3;
    logic [WIDTH-1:0] p_p1, g_p1;
    logic             cin_p1;
    logic [WIDTH-1:0] p_p2, grp_p2;
    logic             cin_p2;
    logic [WIDTH-1:0] diff_p3;
    logic             bout_p3;
    logic             sub_p1, sub_p2;
    logic [WIDTH-1:0] b_x;
    logic             cin_x;
    logic             sub_x;

    assign ld_p3     = ~vld_p3 | out_ready;
    assign ld_p2     = ~vld_p2 | ld_p3;
    assign ld_p1     = ~vld_p1 | ld_p2;
    assign in_ready  = ld_p1;
    assign out_valid = vld_p3;
    assign diff      = diff_p3;
    assign bout      = bout_p3;

`ifdef ADDSUB_MODE_EN
    assign sub_x = op;
`else
    assign sub_x = 1'b1;
`endif
    assign b_x   = sub_x ? ~b : b;
    assign cin_x = sub_x ? ~bin : bin;

    // Stage 1: bitwise propagate/generate and carry-in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            p_p1   <= '0;
            g_p1   <= '0;
            cin_p1 <= 1'b0;
            sub_p1 <= 1'b0;
        end else if (ld_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                p_p1   <= a ^ b_x;
                g_p1   <= a & b_x;
                cin_p1 <= cin_x;
                sub_p1 <= sub_x;
            end
        end
    end

    // Stage 2: full prefix network
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            p_p2   <= '0;
            grp_p2 <= '0;
            cin_p2 <= 1'b0;
            sub_p2 <= 1'b0;
        end else if (ld_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                p_p2   <= p_p1;
                grp_p2 <= sklansky_carry(g_p1, p_p1, cin_p1);
                cin_p2 <= cin_p1;
                sub_p2 <= sub_p1;
            end
        end
    end

    // Stage 3: sum bits and borrow/carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p3  <= 1'b0;
            diff_p3 <= '0;
            bout_p3 <= 1'b0;
        end else if (ld_p3) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                diff_p3 <= p_p2 ^ {grp_p2[WIDTH-2:0], cin_p2};
                bout_p3 <= sub_p2 ? ~grp_p2[WIDTH-1] : grp_p2[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_sklansky_sub_pipe.sv
// Scoreboard bench for sklansky_sub_pipe: vector table, random streaming, stall and async reset.
module tb_sklansky_sub_pipe;

    localparam int W = 8;
    localparam logic OP_SUB = 1'b1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
`ifdef ADDSUB_MODE_EN
    logic         op = 1'b1;
`endif

    always #5 clk = ~clk;

    sklansky_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef ADDSUB_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    res_t exp_q[$];
    int   pop_steps[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_no = 0;
    int   accepts = 0;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin, input logic msub);
        logic [W:0] t;
        res_t r;
        if (msub) t = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        else      t = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mbin};
        r.d  = t[W-1:0];
        r.bo = t[W];
        return r;
    endfunction

    // One clock: drive, observe handshakes half a cycle from the edge, then advance.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic iop, input logic ordy, input res_t e);
        res_t f;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
`ifdef ADDSUB_MODE_EN
        op        = iop;
`endif
        #1;
        if (out_valid && out_ready) begin
            pop_steps.push_back(step_no);
            if (exp_q.size() == 0) begin
                check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                f = exp_q.pop_front();
                check("diff", {24'd0, diff}, {24'd0, f.d});
                check("bout", {31'd0, bout}, {31'd0, f.bo});
            end
        end
        if (in_valid && in_ready) begin
            accepts++;
            exp_q.push_back(e);
        end
        step_no++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, OP_SUB, ordy, '0);
    endtask

    task automatic drain(input int max_cycles);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < max_cycles) begin
            idle(1'b1);
            g++;
        end
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    // Count edges from the accept edge to out_valid, bounded.
    task automatic measure_latency(output int lat);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            idle(1'b1);
            cnt++;
        end
        lat = cnt + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   acc0;
        res_t snap;
        logic [W-1:0] ra, rb;
        logic rbin;

        tbl[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0};
        tbl[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1};
        tbl[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0};
        tbl[3] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1};
        tbl[4] = '{a: 8'hFF, b: 8'hFE, bin: 1'b1, d: 8'h00, bo: 1'b0};
        tbl[5] = '{a: 8'hA5, b: 8'h00, bin: 1'b0, d: 8'hA5, bo: 1'b0};
        tbl[6] = '{a: 8'h3C, b: 8'h3C, bin: 1'b1, d: 8'hFF, bo: 1'b1};
        tbl[7] = '{a: 8'h10, b: 8'h20, bin: 1'b1, d: 8'hEF, bo: 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_diff", {24'd0, diff}, 32'd0);
        check("reset_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);

        // First transaction with latency measurement
        step(1'b1, 8'h05, 8'h03, 1'b0, OP_SUB, 1'b1, '{d: 8'h02, bo: 1'b0});
        measure_latency(lat);
        check("latency_first", lat, 32'd3);
        drain(10);

        // Vector table, back to back
        for (int i = 0; i < 8; i++)
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].bin, OP_SUB, 1'b1, '{d: tbl[i].d, bo: tbl[i].bo});
        drain(10);

        // 16 random accepts with continuous out_ready
        pop_steps.delete();
        acc0 = accepts;
        for (int i = 0; i < 16; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            step(1'b1, ra, rb, rbin, OP_SUB, 1'b1, model(ra, rb, rbin, 1'b1));
        end
        drain(10);
        check("stream_accepts", accepts - acc0, 32'd16);
        check("stream_pops", pop_steps.size(), 32'd16);
        if (pop_steps.size() == 16)
            check("stream_consecutive", pop_steps[15] - pop_steps[0], 32'd15);

        // Fill then stall for 5 cycles
        pop_steps.delete();
        acc0 = accepts;
        step(1'b1, 8'h40, 8'h11, 1'b0, OP_SUB, 1'b0, model(8'h40, 8'h11, 1'b0, 1'b1));
        step(1'b1, 8'h02, 8'h09, 1'b1, OP_SUB, 1'b0, model(8'h02, 8'h09, 1'b1, 1'b1));
        step(1'b1, 8'hC3, 8'h3C, 1'b0, OP_SUB, 1'b0, model(8'hC3, 8'h3C, 1'b0, 1'b1));
        #1;
        check("stall_in_ready_full", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        snap.d  = diff;
        snap.bo = bout;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ra = W'($urandom);
            step(1'b1, ra, 8'h01, 1'b0, OP_SUB, 1'b0, model(ra, 8'h01, 1'b0, 1'b1));
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_diff_hold", {24'd0, diff}, {24'd0, snap.d});
            check("stall_bout_hold", {31'd0, bout}, {31'd0, snap.bo});
        end
        check("stall_accepts", accepts - acc0, 32'd3);
        drain(10);
        check("stall_drain_pops", pop_steps.size(), 32'd3);

        // Asynchronous reset with a full pipeline
        step(1'b1, 8'h77, 8'h11, 1'b0, OP_SUB, 1'b0, model(8'h77, 8'h11, 1'b0, 1'b1));
        step(1'b1, 8'h01, 8'h02, 1'b0, OP_SUB, 1'b0, model(8'h01, 8'h02, 1'b0, 1'b1));
        step(1'b1, 8'h99, 8'h98, 1'b0, OP_SUB, 1'b0, model(8'h99, 8'h98, 1'b0, 1'b1));
        in_valid = 1'b0;
        #2;
        check("prereset_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_diff", {24'd0, diff}, 32'd0);
        check("async_bout", {31'd0, bout}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        pop_steps.delete();
        repeat (4) idle(1'b1);
        check("post_reset_no_output", pop_steps.size(), 32'd0);
        step(1'b1, 8'h00, 8'h01, 1'b0, OP_SUB, 1'b1, '{d: 8'hFF, bo: 1'b1});
        measure_latency(lat);
        check("latency_after_reset", lat, 32'd3);
        drain(10);

`ifdef ADDSUB_MODE_EN
        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, '{d: 8'h00, bo: 1'b1});
        step(1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b1, '{d: 8'h47, bo: 1'b0});
        step(1'b1, 8'h05, 8'h03, 1'b0, 1'b1, 1'b1, '{d: 8'h02, bo: 1'b0});
        drain(10);
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
